mem_sequencer: RTL and testbench

Multi-cycle sequencer that shares one single-port, word-wide, synchronous-read memory between instruction fetch and core data accesses. It sits between the decode/execute controller and the memory array. It arbitrates fetch against load/store, aligns sub-word loads with sign or zero extension, and performs read-modify-write for byte and halfword stores, since the memory has no byte enables.

---
 rtl/mem_sequencer_pkg.sv | 20 ++
 rtl/mem_sequencer_lane.sv | 53 +++++
 rtl/mem_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared types and helpers for the memory sequencer: access size encoding,
// misalignment rule and word-address formation.
package mem_sequencer_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  // Size code 2'b11 is treated as a word everywhere, so it follows the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_sequencer_lane.sv
// Little-endian lane logic: extracts and extends sub-word loads and merges
// sub-word store data into a read word for read-modify-write.
module mem_lane
  import mem_sequencer_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_offset)
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load = i_rdata;
    case (i_size)
      MEM_B:   o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      MEM_H:   o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_rdata;
    endcase

    o_merged = i_rdata;
    case (i_size)
      MEM_B: begin
        case (i_offset)
          2'b00:   o_merged[7:0]   = i_wdata[7:0];
          2'b01:   o_merged[15:8]  = i_wdata[7:0];
          2'b10:   o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      MEM_H: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_sequencer.sv
// Shares one synchronous-read memory between fetch and load/store; data wins
// arbitration, sub-word stores use read-modify-write.
//   state     | meaning
//   IDLE      | arbitrate and latch request, memory outputs quiet
//   D_RD      | present data word address
//   D_RWAIT   | read word available: finish load or register merged word
//   D_WR      | write word / merged word, or report misalignment
//   IF_RD     | present fetch address
//   IF_WAIT   | return fetched word
module mem_sequencer
  import mem_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, D_RD, D_RWAIT, D_WR, IF_RD, IF_WAIT
  } state_e;

  state_e      r_state, w_next;
  logic        r_we, r_uns, r_mis;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merged;
  logic        w_mis;
  logic [31:0] w_load, w_merged, w_waddr;

  assign w_mis   = is_misaligned(d_size, d_addr[1:0]);
  assign w_waddr = word_addr(r_addr);

  mem_lane u_lane (
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_rdata    (mem_rd),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_mis    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merged <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (d_req) begin
          r_we    <= d_we;
          r_uns   <= d_unsigned;
          r_mis   <= w_mis;
          r_size  <= d_size;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else if (if_req) begin
          r_we   <= 1'b0;
          r_mis  <= 1'b0;
          r_addr <= if_addr;
        end
      end
      if (r_state == D_RWAIT) r_merged <= w_merged;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_req) begin
          if (w_mis || (d_we && d_size[1])) w_next = D_WR;
          else                              w_next = D_RD;
        end else if (if_req) begin
          w_next = IF_RD;
        end
      end
      D_RD:    w_next = D_RWAIT;
      D_RWAIT: w_next = r_we ? D_WR : IDLE;
      D_WR:    w_next = IDLE;
      IF_RD:   w_next = IF_WAIT;
      IF_WAIT: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    if_valid = 1'b0;
    if_rdata = '0;
    d_done   = 1'b0;
    d_err    = 1'b0;
    d_rdata  = '0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    busy     = (r_state != IDLE);
    case (r_state)
      D_RD: mem_addr = w_waddr;
      D_RWAIT: begin
        mem_addr = w_waddr;
        if (!r_we) begin
          d_done  = 1'b1;
          d_rdata = w_load;
        end
      end
      D_WR: begin
        d_done = 1'b1;
        if (r_mis) begin
          d_err = 1'b1;
        end else begin
          mem_we   = 1'b1;
          mem_addr = w_waddr;
          mem_wd   = r_size[1] ? r_wdata : r_merged;
        end
      end
      IF_RD: mem_addr = w_waddr;
      IF_WAIT: begin
        mem_addr = w_waddr;
        if_valid = 1'b1;
        if_rdata = mem_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed and randomized checks of mem_sequencer against a byte-level
// reference memory model with latency expectations per transaction kind.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;
  logic        busy;

  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  int          wr_count = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  mem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err),
    .d_rdata(d_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_data;
    else if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wd;
    mem_rd <= tb_mem[mem_addr[9:2]];
  end

  always @(posedge clk) if (mem_we === 1'b1) wr_count <= wr_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_idx = idx; pl_data = data; pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
    ref_mem[idx] = data;
    @(negedge clk);
  endtask

  // Called at a negedge; that cycle (or offs cycles later) is the accept cycle.
  task automatic do_data(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int offs, input logic hold);
    logic        mis, seen;
    logic [7:0]  idx;
    int          nbytes, sh, lat, w0;
    logic [31:0] old, raw, mask, nw;
    mis    = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    idx    = addr[9:2];
    sh     = 8 * int'(addr[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    old    = ref_mem[idx];
    lat    = mis ? 1 : (!we ? 2 : (nbytes == 4 ? 1 : 3));
    raw    = old >> sh;
    if (nbytes < 4) begin
      mask = (32'h1 << (8 * nbytes)) - 32'h1;
      raw  = raw & mask;
      if (!uns && raw[8*nbytes-1]) raw = raw | ~mask;
    end
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nbytes)) - 32'h1) << sh);
    nw   = (we && !mis) ? ((old & ~mask) | ((wd << sh) & mask)) : old;
    d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    w0   = wr_count;
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (d_done === 1'b1) begin
        seen = 1'b1;
        chk("d_latency", 32'(k), 32'(lat + offs));
        chk("d_err", {31'b0, d_err}, {31'b0, mis});
        if (!we || mis) chk("d_rdata", d_rdata, mis ? 32'h0 : raw);
        chk("we_with_done", {31'b0, mem_we}, {31'b0, we && !mis});
        if (we && !mis) begin
          chk("mem_wd", mem_wd, nw);
          chk("mem_addr_wr", mem_addr, {addr[31:2], 2'b00});
        end
        if (!hold) d_req = 1'b0;
      end else if (mem_we !== 1'b0) begin
        chk("we_early", {31'b0, mem_we}, 32'h0);
      end
    end
    chk("d_done_seen", {31'b0, seen}, 32'h1);
    if (!seen) d_req = 1'b0;
    ref_mem[idx] = nw;
    if (!hold) begin
      @(negedge clk);
      chk("write_count", 32'(wr_count - w0), (we && !mis) ? 32'h1 : 32'h0);
      chk("mem_word", tb_mem[idx], nw);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int offs);
    logic seen;
    if_addr = addr; if_req = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        chk("if_latency", 32'(k), 32'(2 + offs));
        chk("if_rdata", if_rdata, ref_mem[addr[9:2]]);
        if_req = 1'b0;
      end
    end
    chk("if_valid_seen", {31'b0, seen}, 32'h1);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    @(negedge clk);
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_d_done", {31'b0, d_done}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // signed and unsigned byte load from top lane
    preload(8'h40, 32'h8844_22F0);
    do_data(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 1'b0);
    chk("lb_signed_const", d_rdata, 32'h0);
    do_data(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 1'b0);

    // byte read-modify-write
    preload(8'h40, 32'h1122_3344);
    do_data(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 0, 1'b0);
    chk("sb_result_const", tb_mem[8'h40], 32'h1122_AB44);

    // priority: word store wins, fetch follows
    if_addr = 32'h0; if_req = 1'b1;
    do_data(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 0, 1'b0);
    do_fetch(32'h0, 0);

    // misaligned halfword load
    do_data(1'b0, 2'd1, 1'b0, 32'h201, 32'h0, 0, 1'b0);

    // back-to-back word loads with req held
    preload(8'h04, 32'h1357_9BDF);
    preload(8'h05, 32'h2468_ACE0);
    do_data(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b1);
    do_data(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1, 1'b0);

    // reset during D_RWAIT of a byte store
    begin
      int w0;
      d_we = 1'b1; d_size = 2'd0; d_addr = 32'h101; d_wdata = 32'hCD; d_req = 1'b1;
      w0 = wr_count;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rr_d_done", {31'b0, d_done}, 32'h0);
      chk("rr_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rr_busy", {31'b0, busy}, 32'h0);
      chk("rr_mem_addr", mem_addr, 32'h0);
      chk("rr_mem_wd", mem_wd, 32'h0);
      chk("rr_d_rdata", d_rdata, 32'h0);
      chk("rr_if_valid", {31'b0, if_valid}, 32'h0);
      d_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rr_no_write", 32'(wr_count - w0), 32'h0);
      chk("rr_mem_word", tb_mem[8'h40], ref_mem[8'h40]);
      rst_n = 1'b1;
      @(negedge clk);
      do_fetch(32'h0, 0);
    end

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) do_fetch(ra, 0);
      else do_data(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), ra, $urandom, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
